// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the data-memory load/store engine:
//   - default widths for data, word address and burst length fields
//   - depth of the attached data memory (64 words)
//   - FSM state encoding used by mem_access_ctrl
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_LEN_W  = 3;
    localparam int MEM_DEPTH  = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

endpackage

// File: rtl/access_counter.sv
// -----------------------------------------------------------------------------
// access_counter
// 16-bit event counter that saturates at 16'hFFFF.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high reset, clears the count
//   inc    in   count one event this cycle
//   clear  in   synchronous clear (has priority over inc)
//   count  out  current count
// -----------------------------------------------------------------------------
module access_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        clear,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Initiator side of the data-memory interface. Accepts single-word stores and
// 1..8 word burst loads, drives the memory enables/addresses, absorbs the
// memory's one-cycle registered read latency and returns load beats with a
// last-beat flag.
//
// Handshake rule (both channels): a transfer happens on the rising clock edge
// where valid and ready are both high. The producer holds its payload stable
// from raising valid until that edge; ready may be asserted independently of
// valid, and ready while valid is low has no effect.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid/req_ready           request channel
//   req_write, req_addr, req_len  store/load, start address, beats-1 (loads)
//   req_wdata                     store data
//   rsp_valid/rsp_ready           load response channel
//   rsp_data, rsp_last            beat data, final-beat flag
//   busy                          controller not in IDLE
//   enable_read/enable_write      memory strobes (never both high)
//   address_read/address_write    memory addresses
//   data_write / data_read        memory write data / registered read data
//   dbg_state                     current FSM state
//   load_beats, store_count       activity counters (ACCESS_COUNT_EN only)
//
// Optional feature macro: ACCESS_COUNT_EN adds the two saturating counters.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              enable_read,
    output logic              enable_write,
    output logic [ADDR_W-1:0] address_read,
    output logic [ADDR_W-1:0] address_write,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output state_t            dbg_state
`ifdef ACCESS_COUNT_EN
    ,
    output logic [15:0]       load_beats,
    output logic [15:0]       store_count
`endif
);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [DATA_W-1:0]   wdata, wdata_n;
    logic [LEN_W-1:0]    beats_left, beats_n;

    // Next-state and next-context logic.
    always_comb begin
        state_n = state;
        addr_n  = addr;
        wdata_n = wdata;
        beats_n = beats_left;
        case (state)
            IDLE: begin
                // req_ready is high exactly when state is IDLE.
                if (req_valid) begin
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    beats_n = req_write ? '0 : req_len;
                    state_n = req_write ? WR : RD_ISSUE;
                end
            end
            WR:       state_n = IDLE;
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT:  state_n = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (beats_left == '0) begin
                        state_n = IDLE;
                    end else begin
                        // Natural ADDR_W-bit wrap gives 63 -> 0 for a
                        // MEM_DEPTH-word memory.
                        addr_n  = addr + 1'b1;
                        beats_n = beats_left - 1'b1;
                        state_n = RD_ISSUE;
                    end
                end
            end
            default:  state_n = IDLE;
        endcase
    end

    // State, context and registered outputs. Outputs are derived from the
    // next state so that they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            wdata         <= '0;
            beats_left    <= '0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            enable_read   <= 1'b0;
            enable_write  <= 1'b0;
            address_read  <= '0;
            address_write <= '0;
            data_write    <= '0;
            rsp_valid     <= 1'b0;
            rsp_last      <= 1'b0;
            rsp_data      <= '0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            wdata         <= wdata_n;
            beats_left    <= beats_n;
            req_ready     <= (state_n == IDLE);
            busy          <= (state_n != IDLE);
            enable_write  <= (state_n == WR);
            address_write <= (state_n == WR) ? addr_n : '0;
            data_write    <= (state_n == WR) ? wdata_n : '0;
            enable_read   <= (state_n == RD_ISSUE);
            address_read  <= (state_n == RD_ISSUE) ? addr_n : '0;
            rsp_valid     <= (state_n == RESP);
            rsp_last      <= (state_n == RESP) && (beats_n == '0);
            // Memory data is valid during RD_WAIT; rsp_data is otherwise
            // held, which keeps it stable under backpressure.
            if (state == RD_WAIT) begin
                rsp_data <= data_read;
            end
        end
    end

    assign dbg_state = state;

`ifdef ACCESS_COUNT_EN
    access_counter u_load_beats (
        .clk   (clk),
        .reset (reset),
        .inc   ((state == RESP) && rsp_ready),
        .clear (1'b0),
        .count (load_beats)
    );

    access_counter u_store_count (
        .clk   (clk),
        .reset (reset),
        .inc   (state == WR),
        .clear (1'b0),
        .count (store_count)
    );
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with a 64x16 registered-read memory
// model attached to the memory port.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [2:0]  req_len = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        enable_read;
  logic        enable_write;
  logic [5:0]  address_read;
  logic [5:0]  address_write;
  logic [15:0] data_write;
  logic [15:0] data_read;
  state_t      dbg_state;
`ifdef ACCESS_COUNT_EN
  logic [15:0] load_beats;
  logic [15:0] store_count;
`endif

  mem_access_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .busy          (busy),
    .enable_read   (enable_read),
    .enable_write  (enable_write),
    .address_read  (address_read),
    .address_write (address_write),
    .data_write    (data_write),
    .data_read     (data_read),
    .dbg_state     (dbg_state)
`ifdef ACCESS_COUNT_EN
    ,
    .load_beats    (load_beats),
    .store_count   (store_count)
`endif
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [64];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      data_read <= '0;
    end else begin
      if (enable_write) mem[address_write] <= data_write;
      if (enable_read) data_read <= mem[address_read];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) check("rd_wr_exclusive", {31'd0, enable_read & enable_write}, 32'd0);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        write;
    logic [5:0]  addr;
    logic [2:0]  len;
    logic [15:0] wdata;
    int          stall;
    logic [15:0] exp [4];
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic w, logic [5:0] a, logic [2:0] l, logic [15:0] d,
                         int st, logic [15:0] e0, logic [15:0] e1, logic [15:0] e2,
                         logic [15:0] e3);
    vec_t v;
    v.write = w; v.addr = a; v.len = l; v.wdata = d; v.stall = st;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge. Returns at the negedge after acceptance with
  // req_valid still high; acc is the cycle in which the handshake occurred.
  task automatic send_req(input logic w, logic [5:0] a, logic [2:0] l, logic [15:0] d,
                          output int acc, output bit ok);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
    for (int t = 0; t < 50; t++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    ok = req_ready;
    acc = cyc;
    if (!ok) begin
      check("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic do_store(input logic [5:0] a, input logic [15:0] d);
    int acc; bit ok;
    send_req(1'b1, a, 3'd0, d, acc, ok);
    req_valid = 1'b0;
    if (!ok) return;
    check("wr_enable", {31'd0, enable_write}, 1);
    check("wr_addr", {26'd0, address_write}, {26'd0, a});
    check("wr_data", {16'd0, data_write}, {16'd0, d});
    check("wr_req_ready", {31'd0, req_ready}, 0);
    @(negedge clk);
    check("wr_back_idle", {31'd0, req_ready}, 1);
  endtask

  task automatic collect_rsp(input int ref_c, input int len, input int stall);
    logic [15:0] hold_d, e;
    logic        hold_l;
    for (int b = 0; b <= len; b++) begin
      int t = 0;
      while (!rsp_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!rsp_valid) begin
        check("rsp_timeout", 0, 1);
        rsp_ready = 1'b0;
        return;
      end
      check("rsp_latency", cyc - ref_c, 3);
      if (b == 0 && stall > 0) begin
        hold_d = rsp_data;
        hold_l = rsp_last;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("bp_valid", {31'd0, rsp_valid}, 1);
          check("bp_data_stable", {16'd0, rsp_data}, {16'd0, hold_d});
          check("bp_last_stable", {31'd0, rsp_last}, {31'd0, hold_l});
          check("bp_req_ready", {31'd0, req_ready}, 0);
          check("bp_no_read", {31'd0, enable_read}, 0);
        end
      end
      rsp_ready = 1'b1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e = 16'hDEAD;
        check("exp_q_empty", 1, 0);
      end
      check("rsp_data", {16'd0, rsp_data}, {16'd0, e});
      check("rsp_last", {31'd0, rsp_last}, (b == len) ? 1 : 0);
      ref_c = cyc;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    check("load_done_valid", {31'd0, rsp_valid}, 0);
    check("load_done_busy", {31'd0, busy}, 0);
  endtask

  task automatic do_load(input logic [5:0] a, input logic [2:0] l, input int stall);
    int acc; bit ok;
    send_req(1'b0, a, l, 16'h0, acc, ok);
    req_valid = 1'b0;
    if (!ok) return;
    collect_rsp(acc, int'(l), stall);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc1, acc2;
    bit ok1, ok2;

    // Table: stores and loads with hand-computed results.
    add_vec(1, 6'd5,  3'd0, 16'hBEEF, 0, 0, 0, 0, 0);
    add_vec(0, 6'd5,  3'd0, 16'h0,    0, 16'hBEEF, 0, 0, 0);
    add_vec(1, 6'd62, 3'd0, 16'h0001, 0, 0, 0, 0, 0);
    add_vec(1, 6'd63, 3'd0, 16'h0002, 0, 0, 0, 0, 0);
    add_vec(1, 6'd0,  3'd0, 16'h0003, 0, 0, 0, 0, 0);
    add_vec(1, 6'd1,  3'd0, 16'h0004, 0, 0, 0, 0, 0);
    add_vec(0, 6'd62, 3'd3, 16'h0,    0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    add_vec(1, 6'd20, 3'd0, 16'hA5A5, 0, 0, 0, 0, 0);
    add_vec(1, 6'd21, 3'd0, 16'h5A5A, 0, 0, 0, 0, 0);
    add_vec(0, 6'd20, 3'd1, 16'h0,    5, 16'hA5A5, 16'h5A5A, 0, 0);
    add_vec(1, 6'd7,  3'd0, 16'hFFFF, 0, 0, 0, 0, 0);
    add_vec(0, 6'd5,  3'd2, 16'h0,    0, 16'hBEEF, 16'h0000, 16'hFFFF, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_enables", {30'd0, enable_read, enable_write}, 0);
    check("rst_addrs", {20'd0, address_read, address_write}, 0);
    check("rst_data", {data_write, rsp_data}, 0);
    check("rst_last", {31'd0, rsp_last}, 0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    reset = 1'b0;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].write) begin
        do_store(vecs[i].addr, vecs[i].wdata);
      end else begin
        for (int b = 0; b <= int'(vecs[i].len); b++) exp_q.push_back(vecs[i].exp[b]);
        do_load(vecs[i].addr, vecs[i].len, vecs[i].stall);
      end
    end

    // Back-to-back: req_valid held high across a store then a load.
    send_req(1'b1, 6'd10, 3'd0, 16'h1234, acc1, ok1);
    if (ok1) check("b2b_wr_enable", {31'd0, enable_write}, 1);
    send_req(1'b0, 6'd10, 3'd0, 16'h0, acc2, ok2);
    req_valid = 1'b0;
    if (ok1 && ok2) begin
      check("b2b_accept_cycle", acc2 - acc1, 2);
      exp_q.push_back(16'h1234);
      collect_rsp(acc2, 0, 0);
    end

    // Reset in RD_WAIT of an 8-beat load.
    send_req(1'b0, 6'd0, 3'd7, 16'h0, acc1, ok1);
    req_valid = 1'b0;
    if (ok1) begin
      @(posedge clk);
      #2;
      check("mid_state_rd_wait", {29'd0, dbg_state}, {29'd0, RD_WAIT});
      reset = 1'b1;
      #1;
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
      check("mid_rst_req_ready", {31'd0, req_ready}, 1);
      check("mid_rst_busy", {31'd0, busy}, 0);
      check("mid_rst_enables", {30'd0, enable_read, enable_write}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_idle", {29'd0, dbg_state}, {29'd0, IDLE});
      exp_q.push_back(16'h0000);
      do_load(6'd0, 3'd0, 0);
    end

`ifdef ACCESS_COUNT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_store(6'd1, 16'h0011);
    do_store(6'd2, 16'h0022);
    do_store(6'd3, 16'h0033);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0033);
    exp_q.push_back(16'h0000);
    do_load(6'd1, 3'd3, 0);
    check("store_count", {16'd0, store_count}, 3);
    check("load_beats", {16'd0, load_beats}, 4);
    force dut.u_store_count.count = 16'hFFFF;
    @(negedge clk);
    release dut.u_store_count.count;
    do_store(6'd4, 16'h0044);
    check("store_count_sat", {16'd0, store_count}, 32'h0000FFFF);
    check("load_beats_hold", {16'd0, load_beats}, 4);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface: the load/store engine between the datapath and the 64x16 data memory.
- Accepts single-word stores and 1-8 word burst loads over a valid/ready request channel.
- Sequences the memory's read/write enables and addresses, and absorbs the memory's one-cycle registered read latency.
- Returns load data over a valid/ready response channel with a last-beat flag.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 6, word address width (64 words).
- LEN_W, 3, burst length field width; beats = req_len+1.

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_write  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  start word address.
- req_len  in  LEN_W  load beats-1; ignored for stores.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  load beat available.
- rsp_ready  in  1  consumer takes beat.
- rsp_data  out  DATA_W  load beat data.
- rsp_last  out  1  final beat of burst.
- busy  out  1  state != IDLE.
- enable_read  out  1  to memory.
- enable_write  out  1  to memory.
- address_read  out  ADDR_W  to memory.
- address_write  out  ADDR_W  to memory.
- data_write  out  DATA_W  to memory.
- data_read  in  DATA_W  from memory; valid the cycle after enable_read.

Behaviour:
- Reset is asynchronous and active-high, on port reset; single clock clk. All outputs and state are registered.
- Reset values: state=IDLE, req_ready=1, all other outputs 0.
- States:
  - IDLE: req_ready=1. On accept: store -> WR; load -> RD_ISSUE. Latch addr, wdata, beats_left=req_len.
  - WR (1 cycle): enable_write=1, address_write=addr, data_write=wdata. Memory commits at the end of this cycle. Next state IDLE.
  - RD_ISSUE (1 cycle): enable_read=1, address_read=addr. Next state RD_WAIT.
  - RD_WAIT (1 cycle): capture data_read into rsp_data. Next state RESP.
  - RESP: rsp_valid=1; rsp_last=(beats_left==0). On rsp_ready:
    - if last -> IDLE;
    - else addr=addr+1 (mod 64 wrap, 63->0), beats_left-1, -> RD_ISSUE.
- Latency:
  - Store accepted in cycle N -> enable_write in N+1 -> readable from N+2.
  - Load accepted in N -> rsp_valid in N+3.
  - Each following beat arrives 3 cycles after the previous handshake.
- Output stability: rsp_data and rsp_last hold stable while rsp_valid=1 and rsp_ready=0 (backpressure of any length).
- req_ready=0 in every state except IDLE; no request is accepted while busy.
- enable_read and enable_write are never both high in the same cycle.
- Reset mid-burst: everything aborts to IDLE immediately. No partial write is issued after reset asserts. The memory's own reset clears its contents.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: ACCESS_COUNT_EN.
- Defined: adds outputs load_beats[15:0] and store_count[15:0].
  - load_beats increments on each completed response handshake; store_count increments on each WR cycle.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_access_pkg: state enum (IDLE, WR, RD_ISSUE, RD_WAIT, RESP), DATA_W/ADDR_W/LEN_W defaults, MEM_DEPTH=64.
- Sub-module access_counter: saturating 16-bit counter with inc and clear, instanced twice under ACCESS_COUNT_EN.
- Everything else lives in one FSM module.

Test Plan:
- Store then load: store addr 5 data 16'hBEEF, then load addr 5 len 0 -> rsp_data=16'hBEEF, rsp_last=1, rsp_valid exactly 3 cycles after load accept.
- Burst wrap: stores 16'h0001..16'h0004 to addr 62,63,0,1; load addr 62 len 3 -> beats 1,2,3,4 in order, rsp_last only on beat 4.
- Backpressure: during a 2-beat load hold rsp_ready=0 for 5 cycles -> rsp_data stable; req_ready=0 and no enable_read pulse while held.
- Back-to-back: req_valid held high with store then load, same addr 10 data 16'h1234 -> second request accepted the cycle after WR; load returns 16'h1234.
- Reset mid-burst: assert reset in RD_WAIT of a len 7 load -> rsp_valid=0, req_ready=1 in the same cycle (async); next load addr 0 -> 16'h0000.
- ACCESS_COUNT_EN: 3 stores plus a 4-beat load -> store_count=3, load_beats=4; preload counter to 16'hFFFF, one more store -> stays 16'hFFFF.
